// File: rtl/status_flag_unit_if.sv
// Bundles the ALU-side flag inputs, checkpoint controls and status outputs of status_flag_unit.
// The master drives the requests and the slave (the flag unit) drives the results.
interface status_flag_unit_if #(
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
);
    logic [FLAG_W-1:0] flags_in;
    logic              update;
    logic [FLAG_W-1:0] update_mask;
    logic              ckpt_push;
    logic              ckpt_restore;
    logic              ckpt_discard;
    logic              err_clr;
    logic [FLAG_W-1:0] flags_out;
    logic [FLAG_W-1:0] flags_fwd;
    logic [CNT_W-1:0]  ckpt_count;
    logic              ckpt_full;
    logic              ckpt_empty;
    logic              ckpt_err;

    modport master (
        output flags_in, update, update_mask, ckpt_push, ckpt_restore, ckpt_discard, err_clr,
        input  flags_out, flags_fwd, ckpt_count, ckpt_full, ckpt_empty, ckpt_err
    );

    modport slave (
        input  flags_in, update, update_mask, ckpt_push, ckpt_restore, ckpt_discard, err_clr,
        output flags_out, flags_fwd, ckpt_count, ckpt_full, ckpt_empty, ckpt_err
    );
endinterface

// File: rtl/status_flag_unit.sv
// Architectural condition flags with masked update, same-cycle bypass and a LIFO of
// flag checkpoints for rolling back speculative paths.
module status_flag_unit #(
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              reset,
    status_flag_unit_if.slave sif
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_RESTORE,
        OP_DISCARD,
        OP_PUSH
    } op_e;

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic [FLAG_W-1:0] stack_q [2**IDX_W];

    logic [FLAG_W-1:0] merged;
    logic [FLAG_W-1:0] fwd;
    logic              empty, full, push_en;
    logic [IDX_W-1:0]  top_idx, wr_idx;
    op_e               op;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign top_idx = IDX_W'(count_q - CNT_W'(1));
    assign wr_idx  = IDX_W'(count_q);

    always_comb begin
        merged = (sif.flags_in & sif.update_mask) | (flags_q & ~sif.update_mask);
        fwd    = (sif.update && !sif.ckpt_restore) ? merged : flags_q;

        // The highest-priority request claims the single stack slot even if it errors.
        op = OP_NONE;
        if (sif.ckpt_restore)      op = OP_RESTORE;
        else if (sif.ckpt_discard) op = OP_DISCARD;
        else if (sif.ckpt_push)    op = OP_PUSH;

        flags_d = sif.update ? merged : flags_q;
        count_d = count_q;
        err_d   = sif.err_clr ? 1'b0 : err_q;
        push_en = 1'b0;

        case (op)
            OP_RESTORE: begin
                if (!empty) begin
                    flags_d = stack_q[top_idx];
                    count_d = count_q - CNT_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_DISCARD: begin
                if (!empty) count_d = count_q - CNT_W'(1);
                else        err_d   = 1'b1;
            end
            OP_PUSH: begin
                if (!full) begin
                    push_en = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Checkpoint storage is deliberately left unreset; entries above count are never read.
    always_ff @(posedge clk) begin
        if (push_en) stack_q[wr_idx] <= fwd;
    end

    assign sif.flags_out  = flags_q;
    assign sif.flags_fwd  = fwd;
    assign sif.ckpt_count = count_q;
    assign sif.ckpt_full  = full;
    assign sif.ckpt_empty = empty;
    assign sif.ckpt_err   = err_q;
endmodule

// File: tb/tb_status_flag_unit.sv
// Scoreboard bench for status_flag_unit: a driver issues directed vectors and queues the
// hand-computed response; a monitor samples the DUT each marked cycle and compares.
module tb_status_flag_unit;
    localparam int FLAG_W = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct {
        string             name;
        logic [FLAG_W-1:0] fwd;
        logic [FLAG_W-1:0] flags;
        logic [CNT_W-1:0]  cnt;
        logic              err;
    } exp_t;

    logic clk;
    logic reset;
    logic step_valid;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    status_flag_unit_if #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) sif ();

    status_flag_unit #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic drive(input logic upd, input logic [3:0] mask, input logic [3:0] fin,
                         input logic push, input logic rest, input logic disc, input logic clr);
        sif.update       = upd;
        sif.update_mask  = mask;
        sif.flags_in     = fin;
        sif.ckpt_push    = push;
        sif.ckpt_restore = rest;
        sif.ckpt_discard = disc;
        sif.err_clr      = clr;
    endtask

    task automatic step(input string name,
                        input logic upd, input logic [3:0] mask, input logic [3:0] fin,
                        input logic push, input logic rest, input logic disc, input logic clr,
                        input logic [3:0] e_fwd, input logic [3:0] e_flags,
                        input int e_cnt, input logic e_err);
        exp_t e;
        drive(upd, mask, fin, push, rest, disc, clr);
        e.name  = name;
        e.fwd   = e_fwd;
        e.flags = e_flags;
        e.cnt   = CNT_W'(e_cnt);
        e.err   = e_err;
        sb_q.push_back(e);
        step_valid = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_outputs_reset(input string name);
        chk({name, "_flags"}, int'(sif.flags_out), 0);
        chk({name, "_cnt"},   int'(sif.ckpt_count), 0);
        chk({name, "_err"},   int'(sif.ckpt_err), 0);
        chk({name, "_empty"}, int'(sif.ckpt_empty), 1);
        chk({name, "_full"},  int'(sif.ckpt_full), 0);
    endtask

    // Monitor: bypass sampled mid-cycle, registered outputs just after the edge.
    initial begin : monitor
        logic [FLAG_W-1:0] fwd_s;
        logic              got;
        exp_t              e;
        forever begin
            got = 1'b0;
            @(negedge clk);
            if (step_valid) begin
                fwd_s = sif.flags_fwd;
                got   = 1'b1;
            end
            @(posedge clk);
            #1;
            if (got) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_fwd"},   int'(fwd_s), int'(e.fwd));
                    chk({e.name, "_flags"}, int'(sif.flags_out), int'(e.flags));
                    chk({e.name, "_cnt"},   int'(sif.ckpt_count), int'(e.cnt));
                    chk({e.name, "_err"},   int'(sif.ckpt_err), int'(e.err));
                    chk({e.name, "_full"},  int'(sif.ckpt_full), (int'(e.cnt) == DEPTH) ? 1 : 0);
                    chk({e.name, "_empty"}, int'(sif.ckpt_empty), (int'(e.cnt) == 0) ? 1 : 0);
                end
            end
        end
    end

    initial begin : driver
        int wait_cyc;
        checks     = 0;
        errors     = 0;
        step_valid = 1'b0;
        reset      = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        idle_outputs_reset("reset");
        @(posedge clk);
        #2;
        reset = 1'b1;

        //    name        upd mask   fin    push rest disc clr   fwd    flags  cnt err
        step("upd_full",  1, 4'hF, 4'hA, 0, 0, 0, 0, 4'hA, 4'hA, 0, 0);
        step("upd_mask",  1, 4'h3, 4'h5, 0, 0, 0, 0, 4'h9, 4'h9, 0, 0);
        step("push1",     1, 4'hF, 4'h1, 1, 0, 0, 0, 4'h1, 4'h1, 1, 0);
        step("push2",     1, 4'hF, 4'h2, 1, 0, 0, 0, 4'h2, 4'h2, 2, 0);
        step("push3",     1, 4'hF, 4'h3, 1, 0, 0, 0, 4'h3, 4'h3, 3, 0);
        step("push4",     1, 4'hF, 4'h4, 1, 0, 0, 0, 4'h4, 4'h4, 4, 0);
        step("push_full", 1, 4'hF, 4'h7, 1, 0, 0, 0, 4'h7, 4'h7, 4, 1);
        step("err_clr",   0, 4'h0, 4'h0, 0, 0, 0, 1, 4'h7, 4'h7, 4, 0);
        step("rest4",     0, 4'h0, 4'h0, 0, 1, 0, 0, 4'h7, 4'h4, 3, 0);
        step("rest3",     0, 4'h0, 4'h0, 0, 1, 0, 0, 4'h4, 4'h3, 2, 0);
        step("rest2",     0, 4'h0, 4'h0, 0, 1, 0, 0, 4'h3, 4'h2, 1, 0);
        step("rest1",     0, 4'h0, 4'h0, 0, 1, 0, 0, 4'h2, 4'h1, 0, 0);
        step("snap_push", 1, 4'hF, 4'h6, 1, 0, 0, 0, 4'h6, 4'h6, 1, 0);
        step("snap_upd",  1, 4'hF, 4'hF, 0, 0, 0, 0, 4'hF, 4'hF, 1, 0);
        step("snap_rest", 0, 4'h0, 4'h0, 0, 1, 0, 0, 4'hF, 4'h6, 0, 0);
        step("top_push",  1, 4'hF, 4'h1, 1, 0, 0, 0, 4'h1, 4'h1, 1, 0);
        step("rest_upd",  1, 4'hF, 4'hF, 0, 1, 0, 0, 4'h1, 4'h1, 0, 0);
        step("pa",        1, 4'hF, 4'h2, 1, 0, 0, 0, 4'h2, 4'h2, 1, 0);
        step("pb",        1, 4'hF, 4'h8, 1, 0, 0, 0, 4'h8, 4'h8, 2, 0);
        step("rest_push", 0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h8, 4'h8, 1, 0);
        step("disc_upd",  1, 4'hC, 4'h5, 0, 0, 1, 0, 4'h4, 4'h4, 0, 0);
        step("disc_emp",  0, 4'h0, 4'h0, 0, 0, 1, 0, 4'h4, 4'h4, 0, 1);
        step("clr_vs_err",0, 4'h0, 4'h0, 0, 0, 1, 1, 4'h4, 4'h4, 0, 1);
        step("clr2",      0, 4'h0, 4'h0, 0, 0, 0, 1, 4'h4, 4'h4, 0, 0);
        step("rest_emp",  1, 4'hF, 4'hC, 0, 1, 0, 0, 4'h4, 4'hC, 0, 1);
        step("hold",      0, 4'h0, 4'h0, 0, 0, 0, 0, 4'hC, 4'hC, 0, 1);
        step("spec_p1",   0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hC, 4'hC, 1, 1);
        step("spec_p2",   1, 4'hF, 4'h3, 1, 0, 0, 0, 4'h3, 4'h3, 2, 1);

        step_valid = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        idle_outputs_reset("async_rst");
        chk("async_rst_fwd", int'(sif.flags_fwd), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;

        step("post_rst",  1, 4'hF, 4'h5, 0, 0, 0, 0, 4'h5, 4'h5, 0, 0);
        step("post_rest", 0, 4'h0, 4'h0, 0, 1, 0, 0, 4'h5, 4'h5, 0, 1);
        step_valid = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        wait_cyc = 0;
        while (sb_q.size() != 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Parametrised successor to the single-level NZCV status register. It holds the architectural condition flags with a per-bit write mask and a same-cycle bypass. It also keeps a LIFO of flag checkpoints so that speculative paths can be rolled back. It sits in the execute stage between the ALU flag outputs and the branch/condition-check logic of the pipelined core.

## Interface
Parameters:
- FLAG_W, 4, number of flag bits; bit order {N,Z,C,V} at [3:0] when FLAG_W=4
- DEPTH, 4, checkpoint entries (legal: 1..16)
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- flags_in  input  FLAG_W  new flag values from ALU
- update  input  1  write flags_in into flag register under mask
- update_mask  input  FLAG_W  per-bit write enable; bit=0 keeps old value
- ckpt_push  input  1  save a checkpoint of the flags
- ckpt_restore  input  1  pop top checkpoint and load it into flags
- ckpt_discard  input  1  pop top checkpoint without loading (speculation resolved correct)
- err_clr  input  1  clear sticky error
- flags_out  output  FLAG_W  registered architectural flags
- flags_fwd  output  FLAG_W  combinational next-flags bypass
- ckpt_count  output  CNT_W  registered number of valid checkpoints
- ckpt_full  output  1  ckpt_count == DEPTH
- ckpt_empty  output  1  ckpt_count == 0
- ckpt_err  output  1  sticky misuse flag

## Operation
- Masked next value: merged = (flags_in & update_mask) | (flags_out & ~update_mask).
- flags_fwd = merged when update && !ckpt_restore; otherwise flags_out. This is purely combinational and has no path from the stack.
- Only one stack operation is honoured per cycle. Priority is restore > discard > push. Lower-priority requests in the same cycle are dropped silently (not an error).
- Restore with count>0:
  - flags_out <= stack[count-1]; count decrements.
  - update in the same cycle is ignored, because that instruction is on the flushed path.
- Discard with count>0: count decrements and flags_out follows normal update rules.
- Push with count<DEPTH:
  - stack[count] <= flags_fwd, so the snapshot includes any same-cycle masked update.
  - count increments and flags_out follows normal update rules.
- Error conditions, each setting ckpt_err:
  - Push when full: push is dropped, flags still update.
  - Restore when empty: restore is dropped and update is then honoured normally.
  - Discard when empty: discard is dropped.
- Any honoured or dropped operation that is not an error leaves ckpt_err unchanged.
- ckpt_err clears on err_clr. If err_clr and a new error occur in the same cycle, the error wins and ckpt_err stays 1.
- With no update and no honoured restore, flags_out holds.
- Stack entries are not cleared on pop. Contents above count are don't-care and must never reach flags_out.

## Timing
- Reset (reset=0, asynchronous): flags_out=0, ckpt_count=0, ckpt_err=0, ckpt_empty=1, ckpt_full=(DEPTH==0, never). Stack contents are not reset.
- Reset deasserts synchronously to clk externally. The first honoured operation is on the first rising edge with reset=1.
- Reset mid-speculation discards all checkpoints; flags return to 0.
- Update latency is 1 cycle: flags_out reflects the update after the edge, and flags_fwd shows it in the same cycle.
- Restore latency is 1 cycle: the restored value appears on flags_out after the edge. flags_fwd during the restore cycle equals the pre-restore flags_out.
- ckpt_count, ckpt_full, ckpt_empty and ckpt_err are registered-derived and change only on the clock edge.
- Back-to-back push/restore every cycle is supported with no bubbles.
- Wrap-around does not occur: count saturates at DEPTH and at 0 via the error rules.

## Test plan
- Reset, then update=1, mask=4'b1111, flags_in=4'b1010 → flags_out=4'b1010 next cycle; during the update cycle flags_fwd=4'b1010.
- flags_out=4'b1010, update with mask=4'b0011, flags_in=4'b0101 → flags_out=4'b1001.
- With DEPTH=4, push at flags 1,2,3,4 (each with a same-cycle update to that value) → count=4 and full=1. Restore ×4 → flags_out 4,3,2,1 on successive cycles, then empty=1.
- Push with update(mask=1111, flags_in=0110) on the same edge → snapshot=0110. Then update flags to 1111, then restore → flags_out=0110.
- Restore+update(flags_in=1111) with top=0001 → flags_out=0001 and update is lost. Restore+push in the same cycle → count decrements by 1 only.
- Misuse and reset:
  - Fifth push when full → ckpt_err=1, count stays 4.
  - Then err_clr → ckpt_err=0.
  - Restore when empty with update(1100, mask 1111) → ckpt_err=1, flags_out=1100.
  - Assert reset mid-sequence → all outputs return to their reset values immediately, without waiting for a clock edge.
